// File: rtl/shapool_pkg.sv
// Shared definitions for the shapool result path: nonce widths, pipeline lag
// and the rebuild of a full 32-bit nonce from pipeline index, base and prefix.
package shapool_pkg;

  localparam int unsigned SHAPOOL_NONCE_LAG = 2;
  localparam int unsigned SHAPOOL_NONCE_W   = 32;
  localparam int unsigned SHAPOOL_MSB_W     = 8;

  // The pipeline index occupies the top idx_w bits, the counter base the rest;
  // the job prefix is then folded into the top byte.
  function automatic logic [31:0] shapool_nonce_rebuild(
    input logic [31:0] idx,
    input logic [31:0] base,
    input logic [7:0]  msb,
    input int unsigned idx_w
  );
    int unsigned base_w;
    logic [31:0] base_mask;
    base_w    = SHAPOOL_NONCE_W - idx_w;
    base_mask = (32'd1 << base_w) - 32'd1;
    return ((idx << base_w) | (base & base_mask)) ^ {msb, 24'h000000};
  endfunction

endpackage

// File: rtl/shapool_result_fifo.sv
// Synchronous register FIFO. The head is shown combinationally; when empty the
// output holds the most recently popped word (zero after reset).
module shapool_result_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DATA_W-1:0]     r_last;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer, occupancy and last-popped tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/shapool_result_collector.sv
// Collects shapool match events, rebuilds one full nonce per matching
// pipeline, queues them and streams them out with sticky drop tracking.
module shapool_result_collector
  import shapool_pkg::*;
#(
  parameter int unsigned POOL_SIZE       = 2,
  parameter int unsigned POOL_SIZE_LOG2  = 1,
  parameter int unsigned NONCE_LAG       = SHAPOOL_NONCE_LAG,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        success,
  input  logic [31:0] nonce,
  input  logic [7:0]  match_flags,
  input  logic [7:0]  nonce_start_MSB,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_nonce,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int unsigned         W        = SHAPOOL_NONCE_W - POOL_SIZE_LOG2;
  localparam logic [W-1:0]         LAG_W    = W'(NONCE_LAG);
  localparam logic [POOL_SIZE-1:0] MASK_ONE = POOL_SIZE'(1);

  logic [POOL_SIZE-1:0]      r_pending_mask;
  logic [W-1:0]              r_pending_base;
  logic [7:0]                r_pending_msb;
  logic                      r_overflow;
  logic [7:0]                r_drop_count;

  logic [POOL_SIZE-1:0]      w_flags;
  logic [W-1:0]              w_base;
  logic                      w_busy;
  logic                      w_event;
  logic                      w_capture;
  logic                      w_drop;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [31:0]               w_push_data;
  logic [POOL_SIZE_LOG2-1:0] w_sel_idx;
  logic                      w_sel_found;
  logic                      w_unused_nonce;

  assign w_flags        = match_flags[POOL_SIZE-1:0];
  assign w_base         = nonce[W-1:0] - LAG_W;
  assign w_busy         = |r_pending_mask;
  assign w_event        = success & (|w_flags);
  assign w_capture      = w_event & ~w_busy;
  assign w_drop         = w_event & w_busy;
  assign w_pop          = result_valid & result_ready;
  assign w_push         = w_busy & (~w_fifo_full | w_pop);
  assign w_push_data    = shapool_nonce_rebuild(32'(w_sel_idx), 32'(r_pending_base),
                                                r_pending_msb, POOL_SIZE_LOG2);
  assign w_unused_nonce = &{1'b0, nonce[31:W]};

  generate
    if (POOL_SIZE < 8) begin : g_unused_flags
      logic w_unused_flags;
      assign w_unused_flags = &{1'b0, match_flags[7:POOL_SIZE]};
    end
  endgenerate

  assign result_valid = ~w_fifo_empty;
  assign overflow     = r_overflow;
  assign drop_count   = r_drop_count;

  // Lowest set pending bit is drained first.
  always_comb begin
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    for (int unsigned i = 0; i < POOL_SIZE; i++) begin
      if (r_pending_mask[i] && !w_sel_found) begin
        w_sel_idx   = POOL_SIZE_LOG2'(i);
        w_sel_found = 1'b1;
      end
    end
  end

  // Pending event capture and per-cycle drain into the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending_mask <= '0;
      r_pending_base <= '0;
      r_pending_msb  <= '0;
    end else if (w_capture) begin
      r_pending_mask <= w_flags;
      r_pending_base <= w_base;
      r_pending_msb  <= nonce_start_MSB;
    end else if (w_push) begin
      r_pending_mask <= r_pending_mask & ~(MASK_ONE << w_sel_idx);
    end
  end

  // Sticky overflow and saturating drop counter for collided events.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  shapool_result_fifo #(
    .DATA_W     (32),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_data      (result_nonce),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

endmodule

// File: tb/tb_shapool_result_collector.sv
// Scoreboard bench for shapool_result_collector with a 4-pipeline pool.
module tb_shapool_result_collector;
  import shapool_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        success;
  logic [31:0] nonce;
  logic [7:0]  match_flags;
  logic [7:0]  nonce_start_MSB;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_nonce;
  logic        overflow;
  logic [7:0]  drop_count;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_pops;
  int unsigned pops_before;
  logic [31:0] sb[$];

  shapool_result_collector #(
    .POOL_SIZE       (4),
    .POOL_SIZE_LOG2  (2),
    .NONCE_LAG       (2),
    .FIFO_DEPTH      (4),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .success         (success),
    .nonce           (nonce),
    .match_flags     (match_flags),
    .nonce_start_MSB (nonce_start_MSB),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_nonce    (result_nonce),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Independent reference: 2-bit pipeline index on top of a 30-bit lagged base.
  function automatic logic [31:0] ref_nonce(input int unsigned idx, input logic [31:0] n,
                                            input logic [7:0] msb);
    logic [31:0] b;
    b = (n - 32'd2) & 32'h3FFF_FFFF;
    return ((32'(idx) << 30) + b) ^ {msb, 24'h000000};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle success strobe; expected results queued unless a drop is expected.
  task automatic send(input logic [7:0] flags, input logic [31:0] n, input logic [7:0] msb,
                      input bit expect_drop);
    success         = 1'b1;
    match_flags     = flags;
    nonce           = n;
    nonce_start_MSB = msb;
    if (!expect_drop) begin
      for (int i = 0; i < 4; i++) begin
        if (flags[i]) sb.push_back(ref_nonce(i, n, msb));
      end
    end
    tick(1);
    success     = 1'b0;
    match_flags = '0;
  endtask

  task automatic wait_drain(input string tag, input int unsigned budget);
    int unsigned c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick(1);
      c++;
    end
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every accepted word is popped from the scoreboard.
  always @(negedge clk) begin
    if (reset_n && result_valid && result_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        check_eq("spurious_out", 32'(sb.size()), 32'd1);
      end else begin
        check_eq("out_nonce", result_nonce, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; n_pops = 0;
    reset_n = 1'b0; success = 1'b0; nonce = '0; match_flags = '0;
    nonce_start_MSB = '0; result_ready = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_nonce", result_nonce, 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    check_eq("rst_drops", 32'(drop_count), 32'd0);
    check_eq("pkg_fn", shapool_nonce_rebuild(32'd2, 32'd3, 8'h00, 2), 32'h8000_0003);

    // Basic two-match event, latency and order.
    result_ready = 1'b1;
    send(8'h05, 32'h0000_0005, 8'h00, 1'b0);
    check_eq("lat_c1_valid", 32'(result_valid), 32'd0);
    tick(1);
    check_eq("lat_c2_valid", 32'(result_valid), 32'd1);
    check_eq("lat_c2_nonce", result_nonce, 32'h0000_0003);
    wait_drain("drain_t1", 20);
    tick(2);
    check_eq("t1_empty", 32'(result_valid), 32'd0);
    check_eq("t1_hold_last", result_nonce, 32'h8000_0003);
    check_eq("t1_ovf", 32'(overflow), 32'd0);

    // Job prefix folded into the top byte.
    send(8'h05, 32'h0000_0005, 8'hA5, 1'b0);
    tick(1);
    check_eq("t2_head", result_nonce, 32'hA500_0003);
    wait_drain("drain_t2", 20);
    tick(2);
    check_eq("t2_last", result_nonce, 32'h2500_0003);

    // Base wraps below zero.
    send(8'h02, 32'h0000_0001, 8'h00, 1'b0);
    wait_drain("drain_t3", 20);
    tick(2);
    check_eq("t3_wrap", result_nonce, 32'h7FFF_FFFF);

    // Backpressure: full FIFO holds a second event in pending without loss.
    result_ready = 1'b0;
    send(8'h0F, 32'h0000_0100, 8'h3C, 1'b0);
    tick(64);
    check_eq("t4_valid", 32'(result_valid), 32'd1);
    check_eq("t4_head", result_nonce, ref_nonce(0, 32'h0000_0100, 8'h3C));
    send(8'h01, 32'h0000_0200, 8'h11, 1'b0);
    tick(5);
    check_eq("t4_ovf", 32'(overflow), 32'd0);
    check_eq("t4_drops", 32'(drop_count), 32'd0);
    pops_before = n_pops;
    result_ready = 1'b1;
    wait_drain("drain_t4", 40);
    check_eq("t4_count", 32'(n_pops - pops_before), 32'd5);

    // Collision while pending is busy: event dropped, pending kept.
    result_ready = 1'b0;
    tick(2);
    send(8'h0F, 32'h0000_0300, 8'h00, 1'b0);
    tick(8);
    send(8'h01, 32'h0000_0400, 8'h00, 1'b0);
    tick(3);
    send(8'h03, 32'h0000_0500, 8'h00, 1'b1);
    check_eq("t5_ovf", 32'(overflow), 32'd1);
    check_eq("t5_drops", 32'(drop_count), 32'd1);
    tick(4);
    check_eq("t5_ovf_sticky", 32'(overflow), 32'd1);
    pops_before = n_pops;
    result_ready = 1'b1;
    wait_drain("drain_t5", 40);
    check_eq("t5_count", 32'(n_pops - pops_before), 32'd5);

    // Reset mid-drain: 3 queued, one still pending.
    result_ready = 1'b0;
    tick(2);
    send(8'h0F, 32'h0000_0600, 8'h00, 1'b0);
    tick(3);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    sb.delete();
    check_eq("t6_valid", 32'(result_valid), 32'd0);
    check_eq("t6_nonce", result_nonce, 32'd0);
    check_eq("t6_ovf", 32'(overflow), 32'd0);
    check_eq("t6_drops", 32'(drop_count), 32'd0);
    pops_before = n_pops;
    result_ready = 1'b1;
    tick(20);
    check_eq("t6_no_out", 32'(n_pops - pops_before), 32'd0);
    check_eq("t6_valid_late", 32'(result_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
